updown_counter_ctl: RTL and testbench

- Parametrised successor to the team's 4-bit free-running counter.
- Adds generic width, up/down direction, synchronous load, enable, programmable terminal value with wrap or saturate mode, and a one-cycle terminal-count pulse.
- Serves as the general-purpose counter/timer primitive for Problem-set datapaths, e.g. address generators and cycle timers.

---
 rtl/updown_counter_ctl.sv | 98 +++++++++
 tb/tb_updown_counter_ctl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/updown_counter_ctl.sv
// rtl/updown_counter_ctl.sv - parametrised up/down counter with load, programmable limit, wrap/saturate and tc pulse
// Optional macro UPDOWN_COUNTER_CTL_STEP_EN adds a per-step increment input (step) in place of the fixed step of 1.
module updown_counter_ctl #(
   parameter int              WIDTH    = 4,
   parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
   parameter bit              SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             lim_we,
   input  logic [WIDTH-1:0] lim_val,
`ifdef UPDOWN_COUNTER_CTL_STEP_EN
   input  logic [WIDTH-1:0] step,
`endif
   output logic [WIDTH-1:0] qd,
   output logic             tc,
   output logic             busy_dir
);

   localparam logic [WIDTH-1:0] LIM_RST = WIDTH'(MAX_VAL);

   logic [WIDTH-1:0] lim;
   logic [WIDTH-1:0] up_nxt;
   logic [WIDTH-1:0] dn_nxt;
   logic             up_cross;
   logic             dn_cross;

`ifdef UPDOWN_COUNTER_CTL_STEP_EN
   logic [WIDTH:0] sum;
   logic [WIDTH:0] modv;
   logic [WIDTH:0] rem_up;
   logic [WIDTH:0] deficit;
   logic [WIDTH:0] rem_dn;

   // Wrap results are taken modulo (lim+1) so that large steps land inside 0..lim.
   always_comb begin
      sum      = {1'b0, qd} + {1'b0, step};
      modv     = {1'b0, lim} + 1'b1;
      rem_up   = sum % modv;
      deficit  = ({1'b0, step} - {1'b0, qd}) % modv;
      rem_dn   = (deficit == '0) ? '0 : (modv - deficit);
      up_cross = (step != '0) && (sum > {1'b0, lim});
      dn_cross = (step != '0) && (step > qd);
      if (step == '0)
         up_nxt = qd;
      else if (up_cross)
         up_nxt = SATURATE ? lim : rem_up[WIDTH-1:0];
      else
         up_nxt = sum[WIDTH-1:0];
      if (step == '0)
         dn_nxt = qd;
      else if (dn_cross)
         dn_nxt = SATURATE ? '0 : rem_dn[WIDTH-1:0];
      else
         dn_nxt = qd - step;
   end
`else
   // qd can sit above lim after a limit write; treat that as a crossing too.
   always_comb begin
      up_cross = (qd >= lim);
      dn_cross = (qd == '0);
      up_nxt   = up_cross ? (SATURATE ? lim : '0) : (qd + 1'b1);
      dn_nxt   = dn_cross ? (SATURATE ? '0 : lim) : (qd - 1'b1);
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         qd       <= '0;
         tc       <= 1'b0;
         busy_dir <= 1'b1;
         lim      <= LIM_RST;
      end else begin
         if (lim_we)
            lim <= lim_val;
         if (load) begin
            qd <= (load_val > lim) ? lim : load_val;
            tc <= 1'b0;
         end else if (en) begin
            busy_dir <= up_dn;
            if (up_dn) begin
               qd <= up_nxt;
               tc <= up_cross;
            end else begin
               qd <= dn_nxt;
               tc <= dn_cross;
            end
         end else begin
            tc <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_updown_counter_ctl.sv
// tb/tb_updown_counter_ctl.sv - scoreboard bench for updown_counter_ctl, wrap and saturate instances side by side
module tb_updown_counter_ctl;

   logic       clk;
   logic       reset;
   logic       en;
   logic       up_dn;
   logic       load;
   logic [3:0] load_val;
   logic       lim_we;
   logic [3:0] lim_val;
   logic [3:0] qd_a, qd_b;
   logic       tc_a, tc_b;
   logic       bd_a, bd_b;
`ifdef UPDOWN_COUNTER_CTL_STEP_EN
   logic [3:0] step;
   initial step = 4'd1;
`endif

   updown_counter_ctl #(.WIDTH(4), .SATURATE(1'b0)) dut_a (
      .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
      .lim_we(lim_we), .lim_val(lim_val),
`ifdef UPDOWN_COUNTER_CTL_STEP_EN
      .step(step),
`endif
      .qd(qd_a), .tc(tc_a), .busy_dir(bd_a));

   updown_counter_ctl #(.WIDTH(4), .SATURATE(1'b1)) dut_b (
      .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
      .lim_we(lim_we), .lim_val(lim_val),
`ifdef UPDOWN_COUNTER_CTL_STEP_EN
      .step(step),
`endif
      .qd(qd_b), .tc(tc_b), .busy_dir(bd_b));

   typedef struct {
      int q;
      bit tc;
      bit dir;
   } exp_t;

   exp_t exp_a[$];
   exp_t exp_b[$];

   int n_chk  = 0;
   int n_fail = 0;

   // Reference state: count values, shared limit, last direction per instance.
   int qa, qb, lim;
   bit da, db;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void ref_next(input bit sat, input int q, input int l, input bit ld, input int lv,
                                    input bit e, input bit ud, output int nq, output bit ntc);
      nq  = q;
      ntc = 1'b0;
      if (ld) begin
         nq = (lv > l) ? l : lv;
      end else if (e && ud) begin
         if (q + 1 > l) begin
            nq  = sat ? l : 0;
            ntc = 1'b1;
         end else begin
            nq = q + 1;
         end
      end else if (e) begin
         if (q - 1 < 0) begin
            nq  = sat ? 0 : l;
            ntc = 1'b1;
         end else begin
            nq = q - 1;
         end
      end
   endfunction

   // Called at a falling edge; applies one cycle of stimulus and returns at the next falling edge.
   task automatic drive(input bit ld, input int lv, input bit e, input bit ud, input bit lwe, input int lval);
      exp_t x;
      int   nq;
      bit   nt;
      load     = ld;
      load_val = 4'(lv);
      en       = e;
      up_dn    = ud;
      lim_we   = lwe;
      lim_val  = 4'(lval);
      if (e && !ld) begin
         da = ud;
         db = ud;
      end
      ref_next(1'b0, qa, lim, ld, lv, e, ud, nq, nt);
      qa = nq;
      x.q = nq; x.tc = nt; x.dir = da;
      exp_a.push_back(x);
      ref_next(1'b1, qb, lim, ld, lv, e, ud, nq, nt);
      qb = nq;
      x.q = nq; x.tc = nt; x.dir = db;
      exp_b.push_back(x);
      if (lwe)
         lim = lval;
      @(negedge clk);
   endtask

   task automatic check_reset_vals();
      check("rst_qd_a", int'(qd_a), 0);
      check("rst_tc_a", int'(tc_a), 0);
      check("rst_dir_a", int'(bd_a), 1);
      check("rst_qd_b", int'(qd_b), 0);
      check("rst_tc_b", int'(tc_b), 0);
      check("rst_dir_b", int'(bd_b), 1);
   endtask

   task automatic do_reset();
      #2 reset = 1'b1;
      #1 check_reset_vals();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      qa = 0; qb = 0; da = 1'b1; db = 1'b1; lim = 15;
   endtask

   initial begin : monitor
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (exp_a.size() > 0) begin
            x = exp_a.pop_front();
            check("a_qd", int'(qd_a), x.q);
            check("a_tc", int'(tc_a), int'(x.tc));
            check("a_dir", int'(bd_a), int'(x.dir));
         end
         if (exp_b.size() > 0) begin
            x = exp_b.pop_front();
            check("b_qd", int'(qd_b), x.q);
            check("b_tc", int'(tc_b), int'(x.tc));
            check("b_dir", int'(bd_b), int'(x.dir));
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int guard;
      reset = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0; lim_we = 1'b0; lim_val = '0;
      qa = 0; qb = 0; da = 1'b1; db = 1'b1; lim = 15;
      #1 check_reset_vals();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Free-run up through the full range and past the top.
      repeat (20) drive(1'b0, 0, 1'b1, 1'b1, 1'b0, 0);
      guard = 0;
      while (qa != 6 && guard < 40) begin
         drive(1'b0, 0, 1'b1, 1'b1, 1'b0, 0);
         guard++;
      end
      check("reach_q6", qa, 6);
      do_reset();

      // Limit 9, wrap up, then down across zero.
      drive(1'b0, 0, 1'b1, 1'b1, 1'b1, 9);
      repeat (12) drive(1'b0, 0, 1'b1, 1'b1, 1'b0, 0);
      guard = 0;
      while (qa != 2 && guard < 20) begin
         drive(1'b0, 0, 1'b1, 1'b1, 1'b0, 0);
         guard++;
      end
      check("reach_q2", qa, 2);
      repeat (4) drive(1'b0, 0, 1'b1, 1'b0, 1'b0, 0);

      // Limit 12, load 10 and count up, then load 1 and count down.
      drive(1'b0, 0, 1'b0, 1'b1, 1'b1, 12);
      drive(1'b1, 10, 1'b0, 1'b1, 1'b0, 0);
      repeat (5) drive(1'b0, 0, 1'b1, 1'b1, 1'b0, 0);
      drive(1'b1, 1, 1'b0, 1'b1, 1'b0, 0);
      repeat (3) drive(1'b0, 0, 1'b1, 1'b0, 1'b0, 0);

      // Load beats enable; load above limit clamps.
      drive(1'b1, 5, 1'b1, 1'b1, 1'b0, 0);
      drive(1'b0, 0, 1'b0, 1'b1, 1'b1, 9);
      drive(1'b1, 14, 1'b0, 1'b1, 1'b0, 0);

      // Idle holds and clears tc.
      drive(1'b1, 7, 1'b0, 1'b0, 1'b0, 0);
      repeat (3) drive(1'b0, 0, 1'b0, 1'b1, 1'b0, 0);

      // Limit dropped below the current count.
      drive(1'b0, 0, 1'b0, 1'b1, 1'b1, 15);
      drive(1'b1, 12, 1'b0, 1'b1, 1'b0, 0);
      drive(1'b0, 0, 1'b0, 1'b1, 1'b1, 5);
      repeat (2) drive(1'b0, 0, 1'b1, 1'b1, 1'b0, 0);
      repeat (2) drive(1'b0, 0, 1'b1, 1'b0, 1'b0, 0);

      // Zero limit.
      drive(1'b0, 0, 1'b0, 1'b1, 1'b1, 0);
      repeat (3) drive(1'b0, 0, 1'b1, 1'b1, 1'b0, 0);
      repeat (3) drive(1'b0, 0, 1'b1, 1'b0, 1'b0, 0);
      drive(1'b1, 7, 1'b0, 1'b1, 1'b0, 0);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 9) == 0, int'($urandom_range(0, 15)), $urandom_range(0, 3) != 0,
               $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0, int'($urandom_range(0, 15)));
         if (i == 200)
            do_reset();
      end

      drive(1'b0, 0, 1'b0, 1'b1, 1'b0, 0);
      guard = 0;
      while ((exp_a.size() != 0 || exp_b.size() != 0) && guard < 5) begin
         @(negedge clk);
         guard++;
      end
      check("drain_a", exp_a.size(), 0);
      check("drain_b", exp_b.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
